logic_unit_arbiter: RTL and testbench

Shares one 32-bit bitwise logic unit between two requesters (ALU execute stage = port 0, bit-manipulation sequencer = port 1). Round-robin arbitration, registered operand capture, and a held result until the requester accepts it. Sits between the requesters and the combinational AND/OR gate arrays of the ALU datapath.

---
 rtl/logic_arb_pkg.sv | 27 ++
 rtl/logic_unit_core.sv | 114 +++++++++++
 rtl/logic_unit_arbiter.sv | 167 ++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_arb_pkg.sv
// ---------------------------------------------------------------------------
// logic_arb_pkg
// Shared definitions for the two-port logic unit arbiter:
//   - state_t       : arbiter FSM states (IDLE, BUSY, DONE)
//   - OP_*          : 2-bit opcode encodings of the logic unit
//   - PORT0 / PORT1 : requester identifiers carried in resp_id
//   - LOGIC_ARB_WIDTH : default operand/result width
// ---------------------------------------------------------------------------
package logic_arb_pkg;

    localparam int LOGIC_ARB_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage : logic_arb_pkg

// File: rtl/logic_unit_core.sv
// ---------------------------------------------------------------------------
// logic_unit_core
// Purely combinational bitwise logic unit built from the datapath gate arrays.
//   i_op     [1:0]       opcode (OP_AND / OP_OR / OP_XOR / OP_NOR)
//   i_a      [WIDTH-1:0] operand A
//   i_b      [WIDTH-1:0] operand B
//   o_result [WIDTH-1:0] bitwise result (0 for an unsupported opcode)
//   o_error              unsupported opcode flag
// Optional feature macro: LOGIC_ARB_XOR_NOR_EN
//   defined   : XOR and NOR are implemented, o_error is always 0
//   undefined : only AND/OR exist, XOR/NOR report o_error=1 with a zero result
// Also contains the gate-array leaf cells used by the core.
// ---------------------------------------------------------------------------

// AND gate array
module logic_and_array #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_a & i_b;
endmodule : logic_and_array

// OR gate array
module logic_or_array #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_a | i_b;
endmodule : logic_or_array

`ifdef LOGIC_ARB_XOR_NOR_EN
// XOR gate array, only present when the XOR/NOR feature is built
module logic_xor_array #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_a ^ i_b;
endmodule : logic_xor_array
`endif

module logic_unit_core
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = LOGIC_ARB_WIDTH
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_error
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;

    logic_and_array #(.WIDTH(WIDTH)) u_and (
        .i_a (i_a),
        .i_b (i_b),
        .o_y (w_and)
    );

    logic_or_array #(.WIDTH(WIDTH)) u_or (
        .i_a (i_a),
        .i_b (i_b),
        .o_y (w_or)
    );

`ifdef LOGIC_ARB_XOR_NOR_EN
    logic [WIDTH-1:0] w_xor;

    logic_xor_array #(.WIDTH(WIDTH)) u_xor (
        .i_a (i_a),
        .i_b (i_b),
        .o_y (w_xor)
    );

    // Opcode decode with the full four-function unit; NOR reuses the OR array
    always_comb begin
        o_result = '0;
        o_error  = 1'b0;
        case (i_op)
            OP_AND:  o_result = w_and;
            OP_OR:   o_result = w_or;
            OP_XOR:  o_result = w_xor;
            OP_NOR:  o_result = ~w_or;
            default: o_result = '0;
        endcase
    end
`else
    // Opcode decode with AND/OR only; anything else is flagged and returns zero
    always_comb begin
        o_result = '0;
        o_error  = 1'b0;
        case (i_op)
            OP_AND: o_result = w_and;
            OP_OR:  o_result = w_or;
            default: begin
                o_result = '0;
                o_error  = 1'b1;
            end
        endcase
    end
`endif

endmodule : logic_unit_core

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
// Shares one bitwise logic unit between two requesters with round-robin
// arbitration, registered operand capture and a held result.
// Ports:
//   clock, reset (async, active-high)
//   req0_valid/req1_valid in   request pending per port
//   req0_ready/req1_ready out  grant this cycle (combinational)
//   req0_op/req1_op       in   2-bit opcode per port
//   req0_operandA/B, req1_operandA/B in WIDTH operands per port
//   resp_valid  out  result available
//   resp_ready  in   consumer accepts result
//   resp_id     out  port that issued the result
//   resp_error  out  unsupported opcode
//   data_result out  WIDTH result
// Optional feature macro: LOGIC_ARB_XOR_NOR_EN (XOR/NOR support in the core).
// Latency: accept at edge N, resp_valid after edge N+2, IDLE after edge N+3
// when resp_ready is high in the first response cycle.
// ---------------------------------------------------------------------------
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = LOGIC_ARB_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_operandA,
    input  logic [WIDTH-1:0] req0_operandB,
    input  logic [WIDTH-1:0] req1_operandA,
    input  logic [WIDTH-1:0] req1_operandB,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic             resp_error,
    output logic [WIDTH-1:0] data_result
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic             r_resp_error;
    logic [WIDTH-1:0] r_data_result;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant_any;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_error;
    logic             w_resp_fire;

    // A port wins when it is the only requester, or when the other port was
    // granted last time. Grants only happen in IDLE.
    assign w_grant0    = (r_state == IDLE) && req0_valid
                         && (!req1_valid || (r_last_grant == PORT1));
    assign w_grant1    = (r_state == IDLE) && req1_valid
                         && (!req0_valid || (r_last_grant == PORT0));
    assign w_grant_any = w_grant0 || w_grant1;
    assign w_resp_fire = r_resp_valid && resp_ready;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_core_result),
        .o_error  (w_core_error)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_any) begin
                    w_state_next = BUSY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BUSY: w_state_next = DONE;
            DONE: begin
                if (w_resp_fire) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: grants are combinational; reset masks them so that the
    // ready outputs read 0 while reset is held even if a request is pending.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Request capture: opcode, operands and issuing port are latched at the
    // grant edge so later changes on the request ports are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= PORT1;
            r_op         <= OP_AND;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= PORT0;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant1 ? PORT1 : PORT0;
            r_op         <= w_grant1 ? req1_op : req0_op;
            r_a          <= w_grant1 ? req1_operandA : req0_operandA;
            r_b          <= w_grant1 ? req1_operandB : req0_operandB;
            r_id         <= w_grant1 ? PORT1 : PORT0;
        end
    end

    // Response registers: result is loaded in BUSY and held until the next
    // operation; resp_valid rises one cycle into DONE and drops on handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_id     <= PORT0;
            r_resp_error  <= 1'b0;
            r_data_result <= '0;
        end else begin
            r_resp_valid <= (r_state == DONE) && !w_resp_fire;
            if (r_state == BUSY) begin
                r_data_result <= w_core_result;
                r_resp_error  <= w_core_error;
                r_resp_id     <= r_id;
            end
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_error  = r_resp_error;
    assign data_result = r_data_result;

endmodule : logic_unit_arbiter

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
// Self-checking bench: directed scenarios followed by randomized transactions,
// checked against a transaction-level reference model of the arbiter.
// Honours LOGIC_ARB_XOR_NOR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_logic_unit_arbiter;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_operandA, req0_operandB, req1_operandA, req1_operandB;
    logic         resp_valid, resp_ready, resp_id, resp_error;
    logic [W-1:0] data_result;

    int n_checks = 0;
    int n_errors = 0;
    int last_grant = 1;   // model: port granted most recently

    always #5 clock = ~clock;

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .req0_op       (req0_op),
        .req1_op       (req1_op),
        .req0_operandA (req0_operandA),
        .req0_operandB (req0_operandB),
        .req1_operandA (req1_operandA),
        .req1_operandB (req1_operandB),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_error    (resp_error),
        .data_result   (data_result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
`ifdef LOGIC_ARB_XOR_NOR_EN
            2'd2: return a ^ b;
            default: return ~(a | b);
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    function automatic logic model_error(input logic [1:0] op);
`ifdef LOGIC_ARB_XOR_NOR_EN
        return 1'b0;
`else
        return op[1];
`endif
    endfunction

    task automatic scramble_inputs();
        req0_valid    = 1'($urandom_range(0, 1));
        req1_valid    = 1'($urandom_range(0, 1));
        req0_op       = 2'($urandom_range(0, 3));
        req1_op       = 2'($urandom_range(0, 3));
        req0_operandA = $urandom;
        req0_operandB = $urandom;
        req1_operandA = $urandom;
        req1_operandB = $urandom;
    endtask

    // One complete transaction, entered shortly after a rising edge while the
    // arbiter is idle; returns shortly after the edge that leaves DONE.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input int hold);
        int win;
        logic [31:0] exp_r;
        logic exp_e;
        req0_valid = v0; req0_op = op0; req0_operandA = a0; req0_operandB = b0;
        req1_valid = v1; req1_op = op1; req1_operandA = a1; req1_operandB = b1;
        if (v0 && v1) win = (last_grant == 1) ? 0 : 1;
        else          win = v0 ? 0 : 1;
        exp_r = (win == 0) ? model_result(op0, a0, b0) : model_result(op1, a1, b1);
        exp_e = (win == 0) ? model_error(op0) : model_error(op1);
        last_grant = win;
        #1;
        check_eq("grant_ready0", 32'(req0_ready), 32'(win == 0));
        check_eq("grant_ready1", 32'(req1_ready), 32'(win == 1));
        @(posedge clock); #1;                   // edge N: captured
        scramble_inputs();
        #1;
        check_eq("busy_ready", 32'(req0_ready | req1_ready), 32'd0);
        check_eq("busy_valid", 32'(resp_valid), 32'd0);
        @(posedge clock); #1;                   // edge N+1
        check_eq("n1_valid", 32'(resp_valid), 32'd0);
        check_eq("n1_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(posedge clock); #1;                   // edge N+2: result visible
        check_eq("resp_valid", 32'(resp_valid), 32'd1);
        check_eq("resp_data", data_result, exp_r);
        check_eq("resp_id", 32'(resp_id), 32'(win));
        check_eq("resp_error", 32'(resp_error), 32'(exp_e));
        for (int k = 0; k < hold; k++) begin
            resp_ready = 1'b0;
            scramble_inputs();
            #1;
            check_eq("stall_ready", 32'(req0_ready | req1_ready), 32'd0);
            @(posedge clock); #1;
            check_eq("stall_valid", 32'(resp_valid), 32'd1);
            check_eq("stall_data", data_result, exp_r);
            check_eq("stall_id", 32'(resp_id), 32'(win));
        end
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("release_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(posedge clock); #1;                   // leave DONE
        resp_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("post_valid", 32'(resp_valid), 32'd0);
        check_eq("post_data_held", data_result, exp_r);
    endtask

    initial begin
        bit v0, v1;
        reset = 1'b1;
        resp_ready = 1'b0;
        scramble_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        check_eq("rst_ready0", 32'(req0_ready), 32'd0);
        check_eq("rst_ready1", 32'(req1_ready), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_id", 32'(resp_id), 32'd0);
        check_eq("rst_error", 32'(resp_error), 32'd0);
        check_eq("rst_data", data_result, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        last_grant = 1;
        @(posedge clock); #1;

        // Contention from reset: port 0 first, then alternation
        do_txn(1, 1, 2'd1, 32'h0000FFFF, 32'hFFFF0000, 2'd0, 32'h12345678, 32'h0F0F0F0F, 0);
        check_eq("tp2_first_data", data_result, 32'hFFFFFFFF);
        check_eq("tp2_first_id", 32'(resp_id), 32'd0);
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 2'd1, $urandom, $urandom, 2'd0, $urandom, $urandom, 0);

        // Port 0 alone, AND
        do_txn(1, 0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 2'd1, 32'h0, 32'h0, 0);
        check_eq("tp1_data", data_result, 32'hF000F000);

        // Long stall with toggling inputs
        do_txn(0, 1, 2'd1, 32'h0, 32'h0, 2'd0, 32'hDEADBEEF, 32'h0000FFFF, 10);

        // XOR opcode (feature dependent)
        do_txn(1, 0, 2'd2, 32'hAAAAAAAA, 32'hFFFFFFFF, 2'd0, 32'h0, 32'h0, 1);
`ifdef LOGIC_ARB_XOR_NOR_EN
        check_eq("tp4_xor_data", data_result, 32'h55555555);
        check_eq("tp4_xor_err", 32'(resp_error), 32'd0);
`else
        check_eq("tp4_xor_data", data_result, 32'h00000000);
        check_eq("tp4_xor_err", 32'(resp_error), 32'd1);
`endif

        // Port 1 alone, back to back
        for (int i = 0; i < 5; i++)
            do_txn(0, 1, 2'd0, 32'h0, 32'h0, 2'($urandom_range(0, 3)), $urandom, $urandom, 0);

        // Reset in BUSY aborts the operation
        req0_valid = 1'b1; req0_op = 2'd1;
        req0_operandA = 32'hFFFFFFFF; req0_operandB = 32'h1;
        req1_valid = 1'b0;
        @(posedge clock); #1;
        #2 reset = 1'b1;
        #1;
        check_eq("abort_valid", 32'(resp_valid), 32'd0);
        check_eq("abort_data", data_result, 32'd0);
        check_eq("abort_id", 32'(resp_id), 32'd0);
        check_eq("abort_error", 32'(resp_error), 32'd0);
        check_eq("abort_ready0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        last_grant = 1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clock); #1;
        end

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            do_txn(v0, v1, 2'($urandom_range(0, 3)), $urandom, $urandom,
                   2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_logic_unit_arbiter
